// File: rtl/axil_pkg.sv
// axil_pkg: response codes, FSM encoding, LFSR seed and the physical
// memory hooks shared by axil_sram_slave and its bench.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] LFSR_SEED   = 4'b1001;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        RD_DLY,
        RD_RSP,
        WR_DLY,
        WR_RSP
    } state_e;

    // Native model behind the pmem_read/pmem_write call interface.
    // Words never written read back as zero.
    logic [31:0] pmem_mem [bit [31:0]];
    int unsigned pmem_wr_calls = 0;

    function automatic logic [31:0] pmem_read(input logic [31:0] addr);
        if (pmem_mem.exists(addr)) begin
            return pmem_mem[addr];
        end
        return 32'h0;
    endfunction

    function automatic void pmem_write(input logic [31:0] addr,
                                       input logic [31:0] data,
                                       input logic [3:0]  mask);
        logic [31:0] word;
        word = pmem_read(addr);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                word[8*i +: 8] = data[8*i +: 8];
            end
        end
        pmem_mem[addr] = word;
        pmem_wr_calls++;
    endfunction

endpackage

// File: rtl/axil_sram_slave_delay_lfsr.sv
// delay_lfsr: 4-bit Fibonacci LFSR (taps 4,3) with enable and reset seed,
// used for randomised response delay.
module delay_lfsr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] seed,
    output logic [3:0] lfsr_o
);

    logic [3:0] lfsr_q;
    logic [3:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/axil_sram_slave.sv
// axil_sram_slave: single-outstanding AXI4-Lite memory responder with
// response delay; AXIL_RANDOM_DELAY_EN swaps LATENCY for an LFSR delay.
module axil_sram_slave
    import axil_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0800_0000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [32:0] WIN_LO = {1'b0, ADDR_BASE};
    localparam logic [32:0] WIN_HI = {1'b0, ADDR_BASE}
                                   + {1'b0, ADDR_SIZE} - 33'd1;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic        bvalid_q, bvalid_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q;
    logic [3:0]  delay;
    logic        rd_fire;
    logic        wr_fire;
    logic        in_range;
    logic [31:0] word_addr;

`ifdef AXIL_RANDOM_DELAY_EN
    logic [3:0] lfsr;

    delay_lfsr u_delay_lfsr (
        .clk    (clk),
        .rst_n  (rst),
        .en     (1'b1),
        .seed   (LFSR_SEED),
        .lfsr_o (lfsr)
    );

    assign delay = lfsr & 4'b0111;
`else
    assign delay = 4'(LATENCY);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rresp_d  = rresp_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        bvalid_d = bvalid_q;

        unique case (state_q)
            BOOT: state_d = IDLE;
            IDLE: begin
                // Reads win; a lone AW or W is left pending.
                priority case (1'b1)
                    arvalid: begin
                        addr_d  = araddr;
                        cnt_d   = delay;
                        state_d = (delay == 4'd0) ? RD_RSP : RD_DLY;
                    end
                    (awvalid && wvalid): begin
                        addr_d  = awaddr;
                        wdata_d = wdata;
                        wstrb_d = wstrb;
                        cnt_d   = delay;
                        state_d = (delay == 4'd0) ? WR_RSP : WR_DLY;
                    end
                    default: ;
                endcase
            end
            RD_DLY: begin
                if (cnt_q == 4'd0) state_d = RD_RSP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WR_DLY: begin
                if (cnt_q == 4'd0) state_d = WR_RSP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RD_RSP: if (rready) state_d = IDLE;
            WR_RSP: if (bready) state_d = IDLE;
            default: state_d = BOOT;
        endcase

        rd_fire   = (state_d == RD_RSP) && (state_q != RD_RSP);
        wr_fire   = (state_d == WR_RSP) && (state_q != WR_RSP);
        in_range  = ({1'b0, addr_d} >= WIN_LO) && ({1'b0, addr_d} <= WIN_HI);
        word_addr = {addr_d[31:2], 2'b00};

        if (rd_fire) begin
            rvalid_d = 1'b1;
            rresp_d  = in_range ? RESP_OKAY : RESP_SLVERR;
        end else if ((state_q == RD_RSP) && rready) begin
            rvalid_d = 1'b0;
        end

        if (wr_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = in_range ? RESP_OKAY : RESP_SLVERR;
        end else if ((state_q == WR_RSP) && bready) begin
            bvalid_d = 1'b0;
        end

        ready_d = (state_d == IDLE);
    end

    // Memory is touched only on the edge that enters a response state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= BOOT;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rresp_q  <= '0;
            bresp_q  <= '0;
            rvalid_q <= 1'b0;
            bvalid_q <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rresp_q  <= rresp_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            bvalid_q <= bvalid_d;
            ready_q  <= ready_d;
            if (rd_fire) begin
                rdata_q <= in_range ? pmem_read(word_addr) : 32'h0;
            end
            if (wr_fire && in_range) begin
                pmem_write(word_addr, wdata_d, wstrb_d);
            end
        end
    end

    assign arready = ready_q;
    assign awready = ready_q;
    assign wready  = ready_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rvalid  = rvalid_q;
    assign bresp   = bresp_q;
    assign bvalid  = bvalid_q;

endmodule

// File: tb/tb_axil_sram_slave.sv
// tb_axil_sram_slave: directed scenarios for axil_sram_slave
// (LATENCY=1 main instance, LATENCY=3 instance for reset-mid-write).
module tb_axil_sram_slave;
    import axil_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    logic        rst2;
    logic [31:0] araddr2, rdata2, awaddr2, wdata2;
    logic        arvalid2, arready2, rvalid2, rready2;
    logic        awvalid2, awready2, wvalid2, wready2, bvalid2, bready2;
    logic [1:0]  rresp2, bresp2;
    logic [3:0]  wstrb2;

    axil_sram_slave #(.LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axil_sram_slave #(.LATENCY(3)) dut3 (
        .clk(clk), .rst(rst2),
        .araddr(araddr2), .arvalid(arvalid2), .arready(arready2),
        .rdata(rdata2), .rresp(rresp2), .rvalid(rvalid2), .rready(rready2),
        .awaddr(awaddr2), .awvalid(awvalid2), .awready(awready2),
        .wdata(wdata2), .wstrb(wstrb2), .wvalid(wvalid2), .wready(wready2),
        .bresp(bresp2), .bvalid(bvalid2), .bready(bready2)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp,
                            output bit ok);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        ok = 1'b0; resp = 2'bxx;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (awready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bvalid) ok = 1'b1;
            else @(negedge clk);
        end
        resp = bresp;
        if (ok) @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output bit ok);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        ok = 1'b0; resp = 2'bxx; d = 'x;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (arready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            arvalid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (rvalid) ok = 1'b1;
            else @(negedge clk);
        end
        d = rdata; resp = rresp;
        if (ok) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0; rst2 = 1'b0;
        araddr = '0; arvalid = 0; rready = 0; awaddr = '0; awvalid = 0;
        wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr2 = '0; arvalid2 = 0; rready2 = 1; awaddr2 = '0; awvalid2 = 0;
        wdata2 = '0; wstrb2 = '0; wvalid2 = 0; bready2 = 0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({arready, awready, wready, rvalid, bvalid, rresp, bresp, rdata}
            !== 41'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%b/%b/%b/%b/%h/%h/%h want=all zero",
                     arready, awready, wready, rvalid, bvalid, rresp, bresp, rdata);
        end
        rst = 1'b1; rst2 = 1'b1;
        #1;
        total++;
        if (arready !== 1'b0) begin
            bad++;
            $display("FAIL boot_ready got=%b want=0", arready);
        end
        @(negedge clk);
        total++;
        if ({arready, awready, wready, awready2} !== 4'b1111) begin
            bad++;
            $display("FAIL idle_ready got=%b want=1111",
                     {arready, awready, wready, awready2});
        end
    endtask

    task automatic test_read;
        logic [1:0] resp;
        bit ok;
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, resp, ok);
        total++;
        if (!ok || resp !== RESP_OKAY) begin
            bad++;
            $display("FAIL preload ok=%0d got=%b want=00", ok, resp);
        end
        araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b1;
        total++;
        if (arready !== 1'b1) begin
            bad++;
            $display("FAIL rd_arready got=%b want=1", arready);
        end
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        total++;
        if (rvalid !== 1'b0) begin
            bad++;
            $display("FAIL rd_lat_n0 got=%b want=0", rvalid);
        end
        @(negedge clk);
        total++;
        if (rvalid !== 1'b0) begin
            bad++;
            $display("FAIL rd_lat_n1 got=%b want=0", rvalid);
        end
        @(negedge clk);
        total++;
        if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL rd_lat_n2 got=%b/%b/%h want=1/00/deadbeef",
                     rvalid, rresp, rdata);
        end
        @(negedge clk);
        total++;
        if ({rvalid, arready} !== 2'b01) begin
            bad++;
            $display("FAIL rd_done got=%b want=01", {rvalid, arready});
        end
    endtask

    task automatic test_partial_write;
        logic [31:0] d;
        logic [1:0]  resp;
        bit ok;
        int unsigned c0;
        do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'hF, resp, ok);
        do_write(32'h8000_0020, 32'h1122_3344, 4'b0101, resp, ok);
        total++;
        if (!ok || resp !== RESP_OKAY) begin
            bad++;
            $display("FAIL pw_bresp ok=%0d got=%b want=00", ok, resp);
        end
        do_read(32'h8000_0020, d, resp, ok);
        total++;
        if (!ok || d !== 32'hFF22_FF44 || resp !== RESP_OKAY) begin
            bad++;
            $display("FAIL pw_readback got=%h/%b want=ff22ff44/00", d, resp);
        end
        c0 = pmem_wr_calls;
        do_write(32'h8000_0020, 32'h0000_0000, 4'b0000, resp, ok);
        total++;
        if (!ok || resp !== RESP_OKAY || pmem_wr_calls !== c0 + 1) begin
            bad++;
            $display("FAIL strb0 got=%b calls=%0d want=00 calls=%0d",
                     resp, pmem_wr_calls, c0 + 1);
        end
        do_read(32'h8000_0023, d, resp, ok);
        total++;
        if (!ok || d !== 32'hFF22_FF44 || resp !== RESP_OKAY) begin
            bad++;
            $display("FAIL misaligned got=%h/%b want=ff22ff44/00", d, resp);
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] d;
        logic [1:0]  resp;
        bit ok;
        int unsigned c0;
        c0 = pmem_wr_calls;
        do_read(32'h0000_0100, d, resp, ok);
        total++;
        if (!ok || d !== 32'h0 || resp !== RESP_SLVERR) begin
            bad++;
            $display("FAIL oor_read got=%h/%b want=00000000/10", d, resp);
        end
        do_write(32'h8800_0000, 32'h1234_5678, 4'hF, resp, ok);
        total++;
        if (!ok || resp !== RESP_SLVERR) begin
            bad++;
            $display("FAIL oor_write got=%b want=10", resp);
        end
        total++;
        if (pmem_wr_calls !== c0 || pmem_read(32'h8800_0000) !== 32'h0) begin
            bad++;
            $display("FAIL oor_nocall calls=%0d want=%0d mem=%h want=0",
                     pmem_wr_calls, c0, pmem_read(32'h8800_0000));
        end
        do_read(32'h7FFF_FFFC, d, resp, ok);
        total++;
        if (!ok || resp !== RESP_SLVERR) begin
            bad++;
            $display("FAIL below_base got=%b want=10", resp);
        end
        do_write(32'h87FF_FFFC, 32'h5A5A_5A5A, 4'hF, resp, ok);
        do_read(32'h87FF_FFFF, d, resp, ok);
        total++;
        if (!ok || d !== 32'h5A5A_5A5A || resp !== RESP_OKAY) begin
            bad++;
            $display("FAIL top_word got=%h/%b want=5a5a5a5a/00", d, resp);
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] resp;
        bit ok;
        do_write(32'h8000_0030, 32'hCAFE_F00D, 4'hF, resp, ok);
        rready = 1'b0;
        araddr = 32'h8000_0030; arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        araddr = 32'h8000_0010;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (rvalid) ok = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bp_rvalid timeout got=0 want=1");
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({rvalid, arready, rdata} !== {2'b10, 32'hCAFE_F00D}) begin
                bad++;
                $display("FAIL bp_stall[%0d] got=%b/%b/%h want=1/0/cafef00d",
                         i, rvalid, arready, rdata);
            end
            @(negedge clk);
        end
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({rvalid, arready} !== 2'b01) begin
            bad++;
            $display("FAIL bp_release got=%b want=01", {rvalid, arready});
        end
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        total++;
        if (arready !== 1'b0) begin
            bad++;
            $display("FAIL bp_next_accept got=%b want=0", arready);
        end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (rvalid) ok = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!ok || rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL bp_second got=%h want=deadbeef", rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_simultaneous;
        logic [31:0] d;
        logic [1:0]  resp;
        bit ok;
        int unsigned c0;
        c0 = pmem_wr_calls;
        araddr = 32'h8000_0040; arvalid = 1'b1; rready = 1'b1;
        awaddr = 32'h8000_0040; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        total++;
        if (awready !== 1'b0 || pmem_wr_calls !== c0) begin
            bad++;
            $display("FAIL sim_rd_first awready=%b calls=%0d want=0 calls=%0d",
                     awready, pmem_wr_calls, c0);
        end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (rvalid) ok = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!ok || rdata !== 32'h0 || rresp !== RESP_OKAY) begin
            bad++;
            $display("FAIL sim_rdata got=%h/%b want=00000000/00", rdata, rresp);
        end
        @(negedge clk);
        total++;
        if ({awready, bvalid} !== 2'b10) begin
            bad++;
            $display("FAIL sim_wr_pending got=%b want=10", {awready, bvalid});
        end
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bvalid) ok = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!ok || bresp !== RESP_OKAY || pmem_wr_calls !== c0 + 1) begin
            bad++;
            $display("FAIL sim_bresp got=%b calls=%0d want=00 calls=%0d",
                     bresp, pmem_wr_calls, c0 + 1);
        end
        @(negedge clk);
        do_read(32'h8000_0040, d, resp, ok);
        total++;
        if (!ok || d !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL sim_readback got=%h want=a5a5a5a5", d);
        end
        c0 = pmem_wr_calls;
        awaddr = 32'h8000_0044;
        for (int i = 0; i < 6; i++) begin
            awvalid = (i < 3);
            wvalid  = (i >= 3);
            @(negedge clk);
            total++;
            if ({awready, bvalid} !== 2'b10) begin
                bad++;
                $display("FAIL lone_channel[%0d] got=%b want=10",
                         i, {awready, bvalid});
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        total++;
        if (pmem_wr_calls !== c0) begin
            bad++;
            $display("FAIL lone_nocall got=%0d want=%0d", pmem_wr_calls, c0);
        end
    endtask

    task automatic test_reset_mid_write;
        bit ok;
        int unsigned c0;
        awaddr2 = 32'h8000_0050; wdata2 = 32'h1111_1111; wstrb2 = 4'hF;
        awvalid2 = 1'b1; wvalid2 = 1'b1; bready2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        awvalid2 = 1'b0; wvalid2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bvalid2 !== 1'b0) begin
                bad++;
                $display("FAIL lat3_wait[%0d] got=%b want=0", i, bvalid2);
            end
            @(negedge clk);
        end
        total++;
        if ({bvalid2, bresp2} !== 3'b100 ||
            pmem_read(32'h8000_0050) !== 32'h1111_1111) begin
            bad++;
            $display("FAIL lat3_resp got=%b/%b mem=%h want=1/00 mem=11111111",
                     bvalid2, bresp2, pmem_read(32'h8000_0050));
        end
        #2 rst2 = 1'b0;
        #1;
        total++;
        if ({bvalid2, awready2} !== 2'b00) begin
            bad++;
            $display("FAIL rst_drop_bvalid got=%b want=00", {bvalid2, awready2});
        end
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        wdata2 = 32'h2222_2222; awvalid2 = 1'b1; wvalid2 = 1'b1;
        ok = (awready2 === 1'b1);
        @(posedge clk);
        @(negedge clk);
        awvalid2 = 1'b0; wvalid2 = 1'b0;
        @(negedge clk);
        c0 = pmem_wr_calls;
        #2 rst2 = 1'b0;
        #1;
        total++;
        if (!ok || bvalid2 !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_dly accepted=%0d bvalid=%b want=1/0",
                     ok, bvalid2);
        end
        @(negedge clk);
        rst2 = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (pmem_read(32'h8000_0050) !== 32'h1111_1111 ||
            pmem_wr_calls !== c0 || bvalid2 !== 1'b0) begin
            bad++;
            $display("FAIL rst_no_commit mem=%h calls=%0d want=11111111 calls=%0d",
                     pmem_read(32'h8000_0050), pmem_wr_calls, c0);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_partial_write();
        test_out_of_range();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_sram_slave.md
Name: axil_sram_slave

Overview:
- AXI4-Lite responder that services the core's load/store initiator; it is the memory end of the data-access path fed by the execute stage's computed addresses.
- Backs onto simulated physical memory through the DPI-C functions pmem_read/pmem_write and inserts a configurable response latency.
- Handles a single transaction at a time.

Parameters:
- ADDR_BASE, 32'h8000_0000, lowest legal byte address.
- ADDR_SIZE, 32'h0800_0000, size in bytes of the legal window.
- LATENCY, 1, wait cycles between address acceptance and response valid (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  32  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready

Behaviour:
- Reset (rst=0, asynchronous):
  - state=BOOT; all outputs 0, including arready, awready, wready, rvalid, bvalid, rdata, rresp and bresp.
  - Delay counter is cleared.
- States and transitions:
  - BOOT goes to IDLE one cycle after reset deasserts.
  - IDLE: arready=1, awready=1, wready=1. All ready outputs are registered and low in every other state.
  - From IDLE:
    - arvalid=1 → latch araddr, go to RD_DLY (or RD_RSP if the delay is 0).
    - Otherwise, awvalid=1 and wvalid=1 together → latch awaddr, wdata and wstrb, go to WR_DLY (or WR_RSP).
    - awvalid or wvalid alone is not accepted; the block stays in IDLE.
  - Read has priority: when arvalid, awvalid and wvalid are all high, only AR handshakes. AW and W stay pending.
  - RD_DLY / WR_DLY: the counter loads the delay at acceptance and decrements each cycle. At 0 the block goes to the matching RSP state.
  - Entering RD_RSP:
    - In range: call pmem_read on the word-aligned address ({addr[31:2],2'b00}), register the result into rdata, rresp=2'b00.
    - Out of range: rdata=32'h0, rresp=2'b10, no DPI call.
    - rvalid=1.
  - Entering WR_RSP:
    - In range: call pmem_write(aligned addr, wdata, wstrb), bresp=2'b00.
    - Out of range: no call, bresp=2'b10.
    - bvalid=1.
  - RD_RSP holds rvalid, rdata and rresp stable until rready=1. rvalid drops on the next cycle and the block returns to IDLE. WR_RSP behaves the same with bvalid/bready.
- Latency: with AR handshake at edge N, rvalid rises at edge N+1+LATENCY. Minimum occupancy is LATENCY+2 cycles per transaction.
- Range check: an address is legal when ADDR_BASE ≤ addr ≤ ADDR_BASE+ADDR_SIZE-1. Use 33-bit arithmetic so the window end never wraps.
- wstrb=4'b0000: the write completes with OKAY; pmem_write is still called, with mask 0.
- Reset mid-transaction:
  - Any transaction is abandoned immediately and rvalid/bvalid drop.
  - A write whose WR_RSP transition has not occurred is never committed.
- Misaligned address: the low two bits are ignored and no error is raised.

Optional Feature:
- Macro: AXIL_RANDOM_DELAY_EN.
- Defined:
  - A 4-bit Fibonacci LFSR (taps 4,3; seed 4'b1001 at reset) advances every cycle.
  - The delay at acceptance is lfsr[2:0] (0..7) instead of LATENCY.
- Undefined: the LFSR is absent and the delay is always LATENCY.

Decomposition:
- Package axil_pkg holds:
  - Response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - The state encoding: BOOT, IDLE, RD_DLY, RD_RSP, WR_DLY, WR_RSP.
  - The DPI import declarations for pmem_read/pmem_write.
- One sub-module, delay_lfsr: 4-bit LFSR with enable and seed. It is instantiated only under AXIL_RANDOM_DELAY_EN.

Test Plan:
- Reset release then read:
  - Stimulus: preload 0x8000_0010=32'hDEAD_BEEF, LATENCY=1, arvalid with araddr=0x8000_0010, rready=1.
  - Response: arready=1 from the cycle after BOOT; rvalid at edge N+2 with rdata=DEADBEEF and rresp=00.
- Partial write:
  - Stimulus: write awaddr=0x8000_0020, wdata=32'h1122_3344, wstrb=4'b0101 over an existing 0xFFFF_FFFF, then read back the same address.
  - Response: read returns 32'hFF22_FF44; bresp=00.
- Out-of-range accesses:
  - Stimulus: read at 0x0000_0100, then write at 0x8800_0000.
  - Response: rresp=10 with rdata=0; bresp=10; memory unchanged and no DPI call.
- Backpressure:
  - Stimulus: hold rready=0 for 5 cycles after rvalid.
  - Response: rvalid and rdata stay stable; arready stays 0 throughout; the next AR is accepted the cycle after the R handshake.
- Simultaneous read and write:
  - Stimulus: arvalid, awvalid and wvalid rise together.
  - Response: read completes first and the write is accepted in the next IDLE; awvalid alone with wvalid=0 is never accepted.
- Reset mid-write:
  - Stimulus: assert rst=0 during WR_DLY with LATENCY=3.
  - Response: bvalid=0 immediately and the target word is unchanged.
